// File: rtl/instr_fetch_if.sv
// Handshake bundle of the fetch unit: PC input, instruction-memory request/response,
// decode-side output and flush. The fetch unit uses the slave view; its environment uses the master view.
interface instr_fetch_if;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_misalign;
   logic        flush;

   modport slave (
      input  pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, flush,
      output pc_ready, imem_req_valid, imem_addr, inst_valid, inst_out, inst_pc, inst_misalign
   );

   modport master (
      output pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, flush,
      input  pc_ready, imem_req_valid, imem_addr, inst_valid, inst_out, inst_pc, inst_misalign
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: at most one instruction-memory read in flight, results queued in order
// toward decode. Misaligned PCs skip memory and enqueue a NOP tagged as misaligned.
module instr_fetch #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
   input  logic         i_clk,
   input  logic         i_reset,
   instr_fetch_if.slave bus
);
   localparam int unsigned    PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [31:0]      r_pc;
   logic             r_ready_en;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [31:0]      r_fifo_insn [FIFO_DEPTH];
   logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
   logic             r_fifo_mis  [FIFO_DEPTH];

   logic        w_pc_hs;
   logic        w_misaligned;
   logic        w_push_fetch;
   logic        w_push;
   logic        w_pop;
   logic        w_empty;
   logic [31:0] w_push_insn;
   logic [31:0] w_push_pc;

   // Only entered from IDLE, where nothing is in flight, so occupancy alone reserves the slot.
   assign bus.pc_ready = r_ready_en && (r_state == IDLE) && !bus.flush && (r_count < DEPTH_CNT);

   assign w_pc_hs      = bus.pc_valid & bus.pc_ready;
   assign w_misaligned = |bus.pc_in[1:0];
   assign w_push_fetch = (r_state == WAIT) & bus.imem_rsp_valid & ~bus.flush;
   assign w_push       = w_push_fetch | (w_pc_hs & w_misaligned);
   assign w_push_insn  = w_push_fetch ? bus.imem_rsp_data : NOP_INSN;
   assign w_push_pc    = w_push_fetch ? r_pc : bus.pc_in;
   assign w_empty      = (r_count == '0);
   assign w_pop        = ~w_empty & bus.inst_ready & ~bus.flush;

   assign bus.imem_req_valid = (r_state == REQ);
   assign bus.imem_addr      = r_pc;
   assign bus.inst_valid     = ~w_empty;
   assign bus.inst_out       = w_empty ? 32'h0 : r_fifo_insn[r_rd_ptr];
   assign bus.inst_pc        = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
   assign bus.inst_misalign  = w_empty ? 1'b0  : r_fifo_mis[r_rd_ptr];

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_pc_hs && !w_misaligned) w_state_next = REQ;
         end
         REQ: begin
            if (bus.flush)               w_state_next = bus.imem_req_ready ? DROP : IDLE;
            else if (bus.imem_req_ready) w_state_next = WAIT;
         end
         WAIT: begin
            if (bus.imem_rsp_valid) w_state_next = IDLE;
            else if (bus.flush)     w_state_next = DROP;
         end
         DROP: begin
            // The owed response retires the drop even under a new flush; nothing else is outstanding.
            if (bus.imem_rsp_valid) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_ready_en <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_ready_en <= 1'b1;
         if (w_pc_hs && !w_misaligned) r_pc <= bus.pc_in;
         if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Storage needs no reset: the outputs are masked while the buffer is empty.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_insn[r_wr_ptr] <= w_push_insn;
         r_fifo_pc[r_wr_ptr]   <= w_push_pc;
         r_fifo_mis[r_wr_ptr]  <= ~w_push_fetch;
      end
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the number of fetched-instruction buffer entries (power of two, minimum 2).
REQ-002 Parameter NOP_INSN, default 32'h00000013, SHALL set the instruction word substituted on a misaligned fetch.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; it SHALL assert immediately and deassert synchronously to clk.
REQ-005 pc_in  input  32  fetch address from the program counter.
REQ-006 pc_valid  input  1  pc_in is valid this cycle.
REQ-007 pc_ready  output  1  fetch unit accepts pc_in this cycle (handshake when pc_valid & pc_ready).
REQ-008 imem_req_valid  output  1  instruction-memory read request valid.
REQ-009 imem_req_ready  input  1  instruction memory accepts the request.
REQ-010 imem_addr  output  32  word-aligned request address.
REQ-011 imem_rsp_valid  input  1  read data valid; exactly one response per accepted request, at least one cycle after acceptance.
REQ-012 imem_rsp_data  input  32  instruction word.
REQ-013 inst_valid  output  1  buffer head valid toward decode.
REQ-014 inst_ready  input  1  decode consumes the head this cycle.
REQ-015 inst_out  output  32  head instruction word.
REQ-016 inst_pc  output  32  address the head instruction was fetched from.
REQ-017 inst_misalign  output  1  head entry came from a misaligned pc_in (pc_in[1:0] != 0).
REQ-018 flush  input  1  single-cycle discard of all buffered and in-flight fetches.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, DROP, and at most one memory request SHALL be outstanding.
REQ-020 pc_ready SHALL be 1 only in IDLE, with flush = 0 and (occupancy + in-flight) < FIFO_DEPTH.
REQ-021 An aligned PC handshake in IDLE SHALL latch pc_in and enter REQ, and imem_req_valid SHALL be 1 in REQ with imem_addr = latched PC.
REQ-022 imem_req_valid and imem_addr SHALL hold stable in REQ until imem_req_ready; the handshake SHALL enter WAIT.
REQ-023 In WAIT, imem_rsp_valid SHALL push {latched PC, imem_rsp_data, misalign=0} and return to IDLE, so inst_valid rises on the cycle after the response.
REQ-024 A misaligned PC handshake SHALL issue no memory request, push {pc_in, NOP_INSN, misalign=1} on the same edge, and remain in IDLE.
REQ-025 The buffer SHALL be FIFO order, and a pop (inst_valid & inst_ready) and a push on the same edge SHALL both take effect with occupancy unchanged.
REQ-026 The slot reservation in REQ-020 SHALL guarantee a push never meets a full buffer; the write pointer and read pointer SHALL wrap modulo FIFO_DEPTH.
REQ-027 flush SHALL empty the buffer on that edge, with inst_valid = 0 on the following cycle and any same-cycle pop or push ignored.
REQ-028 flush in REQ without a same-cycle imem_req_ready SHALL return to IDLE and deassert imem_req_valid on the next cycle.
REQ-029 flush in REQ with a same-cycle imem_req_ready, or flush in WAIT without a same-cycle response, SHALL enter DROP.
REQ-030 flush in WAIT with a same-cycle response SHALL discard that response and enter IDLE.
REQ-031 In DROP, imem_rsp_valid SHALL be consumed without a push, followed by IDLE, and a flush in DROP SHALL keep the FSM in DROP.
REQ-032 imem_rsp_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-033 While reset = 0, the FSM SHALL be IDLE, the buffer empty and pointers 0, and pc_ready, imem_req_valid, inst_valid, inst_misalign = 0 with imem_addr, inst_out, inst_pc = 32'h00000000.
REQ-034 Reset asserted mid-request SHALL abandon the request without tracking its response, and the first pc_ready = 1 SHALL occur one cycle after reset release.

Verification
REQ-035 Aligned fetch: pc_in=32'h00000010 handshake, imem_req_ready=1 the next cycle, response 32'h00500093 two cycles later -> inst_valid=1 one cycle after the response, with inst_out=32'h00500093, inst_pc=32'h00000010, inst_misalign=0.
REQ-036 Backpressure: inst_ready=0 with PCs 0x0, 0x4, 0x8 offered -> two entries buffered, pc_ready=0 after the second handshake, 0x8 accepted only after one pop, and output order 0x0, 0x4, 0x8.
REQ-037 Misaligned: pc_in=32'h00000006 -> no imem_req_valid, next cycle inst_valid=1 with inst_out=32'h00000013 and inst_misalign=1.
REQ-038 Flush in WAIT: response arrives two cycles after flush -> response discarded, inst_valid stays 0, pc_ready=1 the cycle after the response, and the next fetch of 0x40 returns correctly.
REQ-039 Memory stall: imem_req_ready=0 for 5 cycles -> imem_addr stable for all 5 cycles; flush on cycle 3 -> imem_req_valid=0 on cycle 4 with no push.
REQ-040 Reset mid-WAIT: reset=0 asynchronously -> all outputs go to the REQ-033 values immediately, and the post-release fetch of 0x0 is unaffected by the stale response.
